// File: rtl/breadboard_pkg.sv
// breadboard_pkg: shared FSM state type, parameter limits and the
// table-depth helper used by lut_breadboard and lut_sweep_ctrl.
package breadboard_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } bb_state_t;

   localparam int N_IN_MIN  = 1;
   localparam int N_IN_MAX  = 8;
   localparam int N_OUT_MIN = 1;
   localparam int N_OUT_MAX = 32;

   function automatic int rows_of(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/lut_sweep_ctrl.sv
// lut_sweep_ctrl: IDLE/SWEEP FSM, sweep row counter and slot-free logic.
// Ports: i_clk, i_rst_n; i_sweep_start; i_out_valid/i_out_ready (output
//   slot status); o_idle, o_slot_free, o_load (sweep row load strobe),
//   o_row (row to load), o_busy, o_done (one-cycle end-of-sweep pulse).
module lut_sweep_ctrl
   import breadboard_pkg::*;
#(
   parameter int N_IN = 4
)(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_sweep_start,
   input  logic            i_out_valid,
   input  logic            i_out_ready,
   output logic            o_idle,
   output logic            o_slot_free,
   output logic            o_load,
   output logic [N_IN-1:0] o_row,
   output logic            o_busy,
   output logic            o_done
);

   localparam int CW = N_IN + 1;
   // Counter value once every row has been loaded; one bit wider than
   // the row index so it never wraps back to row 0.
   localparam logic [CW-1:0] LAST_CNT = CW'(rows_of(N_IN));

   bb_state_t     r_state;
   bb_state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic          w_slot_free;
   logic          w_all_loaded;

   assign w_slot_free  = !i_out_valid || i_out_ready;
   assign w_all_loaded = (r_cnt == LAST_CNT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      o_load      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_sweep_start) begin
               w_state_nxt = SWEEP;
               w_cnt_nxt   = '0;
            end
         end
         SWEEP: begin
            if (!w_all_loaded) begin
               if (w_slot_free) begin
                  o_load    = 1'b1;
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end else if (i_out_valid && i_out_ready) begin
               // Last row consumed: finish and rearm for the next sweep.
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_idle      = (r_state == IDLE);
   assign o_busy      = (r_state == SWEEP);
   assign o_slot_free = w_slot_free;
   assign o_row       = r_cnt[N_IN-1:0];
   assign o_done      = r_done;

endmodule

// File: rtl/lut_breadboard.sv
// lut_breadboard: N_OUT programmable truth tables over N_IN inputs with a
// registered single-row eval port and an automatic all-rows sweep.
// Ports: clk, rst_n; cfg_valid/cfg_ready/cfg_sel/cfg_table (table write);
//   in_valid/in_ready/in_data (eval); out_valid/out_ready/out_data/out_row
//   (result); sweep_start/sweep_busy/sweep_done (sweep control).
// Option BREADBOARD_PARITY_EN adds out_parity, registered as ^out_data.
module lut_breadboard
   import breadboard_pkg::*;
#(
   parameter  int N_IN  = 4,
   parameter  int N_OUT = 10,
   localparam int ROWS  = rows_of(N_IN),
   localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [SEL_W-1:0] cfg_sel,
   input  logic [ROWS-1:0]  cfg_table,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_OUT-1:0] out_data,
   output logic [N_IN-1:0]  out_row,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done
`ifdef BREADBOARD_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   if (N_IN < N_IN_MIN || N_IN > N_IN_MAX ||
       N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX) begin : g_bad_param
      $error("lut_breadboard: N_IN or N_OUT out of range");
   end

   logic [ROWS-1:0]  r_table [N_OUT];
   logic             r_out_valid;
   logic [N_OUT-1:0] r_out_data;
   logic [N_IN-1:0]  r_out_row;

   logic             w_idle;
   logic             w_slot_free;
   logic             w_load_sweep;
   logic [N_IN-1:0]  w_sweep_row;
   logic             w_eval;
   logic             w_cfg_we;
   logic             w_load;
   logic [N_IN-1:0]  w_row;
   logic [N_OUT-1:0] w_data;

   lut_sweep_ctrl #(
      .N_IN (N_IN)
   ) u_ctrl (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_sweep_start (sweep_start),
      .i_out_valid   (r_out_valid),
      .i_out_ready   (out_ready),
      .o_idle        (w_idle),
      .o_slot_free   (w_slot_free),
      .o_load        (w_load_sweep),
      .o_row         (w_sweep_row),
      .o_busy        (sweep_busy),
      .o_done        (sweep_done)
   );

   assign cfg_ready = w_idle;
   assign in_ready  = w_idle && w_slot_free;
   assign w_eval    = in_valid && in_ready;
   assign w_cfg_we  = cfg_valid && cfg_ready;
   assign w_load    = w_eval || w_load_sweep;
   assign w_row     = w_eval ? in_data : w_sweep_row;

   // Lookup reads the registered tables, so a write on the same edge
   // is only seen by later lookups.
   always_comb begin
      w_data = '0;
      for (int k = 0; k < N_OUT; k++) begin
         w_data[k] = r_table[k][w_row];
      end
   end

   // Selects >= N_OUT match no table and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_OUT; k++) begin
            r_table[k] <= '0;
         end
      end else if (w_cfg_we) begin
         for (int k = 0; k < N_OUT; k++) begin
            if (int'(cfg_sel) == k) begin
               r_table[k] <= cfg_table;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_row   <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_row   <= w_row;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_row   = r_out_row;

`ifdef BREADBOARD_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (w_load) begin
         r_parity <= ^w_data;
      end
   end

   assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_lut_breadboard.sv
// tb_lut_breadboard: randomized scoreboard bench for lut_breadboard.
// Stimulus pushes expected rows; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lut_breadboard;

   localparam int N_IN  = 4;
   localparam int N_OUT = 10;
   localparam int ROWS  = 16;
   localparam int SEL_W = 4;
   localparam int QD    = 256;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [SEL_W-1:0] cfg_sel = '0;
   logic [ROWS-1:0]  cfg_table = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N_IN-1:0]  in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [N_OUT-1:0] out_data;
   logic [N_IN-1:0]  out_row;
   logic             sweep_start = 1'b0;
   logic             sweep_busy;
   logic             sweep_done;
`ifdef BREADBOARD_PARITY_EN
   logic             out_parity;
`endif

   lut_breadboard #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_sel     (cfg_sel),
      .cfg_table   (cfg_table),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .sweep_start (sweep_start),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done)
`ifdef BREADBOARD_PARITY_EN
      ,
      .out_parity  (out_parity)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the tables as plain bit vectors.
   logic [ROWS-1:0]  model [N_OUT];
   // Expected-result FIFO: stimulus writes wr_ptr, monitor owns rd_ptr.
   logic [N_IN-1:0]  q_row  [QD];
   logic [N_OUT-1:0] q_data [QD];
   bit               q_last [QD];
   int               wr_ptr = 0;
   int               rd_ptr = 0;
   int               sw_started = 0;
   int               sw_finished = 0;
   bit               tmo_flag = 1'b0;
   bit               tmo_seen = 1'b0;
   bit               hold5_en = 1'b0;
   bit               rdy_rand = 1'b0;
   int               hold_n = 0;
   int               checks = 0;
   int               errors = 0;
   bit               clear_pend = 1'b0;
   bit               exp_done = 1'b0;
   bit               mbusy = 1'b0;
   int               idx = 0;

   function automatic bit busy_now();
      return sw_started != sw_finished;
   endfunction

   function automatic logic [N_OUT-1:0] lookup(input logic [N_IN-1:0] row);
      logic [N_OUT-1:0] v;
      v = '0;
      for (int k = 0; k < N_OUT; k++) v[k] = model[k][row];
      return v;
   endfunction

   task automatic push(input logic [N_IN-1:0] row, input bit last);
      q_row[wr_ptr % QD]  = row;
      q_data[wr_ptr % QD] = lookup(row);
      q_last[wr_ptr % QD] = last;
      wr_ptr++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares every negedge; pops when the result is consumed.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      = wr_ptr;
         sw_finished = sw_started;
         clear_pend  = 1'b0;
         exp_done    = 1'b0;
         #1;
         chk("rst out_valid", 32'(out_valid), 32'd0);
         chk("rst out_data", 32'(out_data), 32'd0);
         chk("rst out_row", 32'(out_row), 32'd0);
         chk("rst sweep_busy", 32'(sweep_busy), 32'd0);
         chk("rst sweep_done", 32'(sweep_done), 32'd0);
`ifdef BREADBOARD_PARITY_EN
         chk("rst out_parity", 32'(out_parity), 32'd0);
`endif
      end else begin
         if (tmo_flag && !tmo_seen) begin
            tmo_seen = 1'b1;
            checks++;
            errors++;
            $display("FAIL timeout: DUT did not respond within cycle budget");
         end
         exp_done = clear_pend;
         if (clear_pend) begin
            sw_finished++;
            clear_pend = 1'b0;
         end
         mbusy = busy_now();
         chk("sweep_done", 32'(sweep_done), 32'(exp_done));
         chk("sweep_busy", 32'(sweep_busy), 32'(mbusy));
         chk("cfg_ready", 32'(cfg_ready), 32'(!mbusy));
         chk("in_ready", 32'(in_ready),
             32'(!mbusy && (!out_valid || out_ready)));
         if (out_valid) begin
            if (rd_ptr == wr_ptr) begin
               checks++;
               errors++;
               $display("FAIL unexpected output: row %0h data %0h, none expected",
                        out_row, out_data);
            end else begin
               idx = rd_ptr % QD;
               chk("out_row", 32'(out_row), 32'(q_row[idx]));
               chk("out_data", 32'(out_data), 32'(q_data[idx]));
`ifdef BREADBOARD_PARITY_EN
               chk("out_parity", 32'(out_parity), 32'(^q_data[idx]));
`endif
               if (out_ready) begin
                  if (q_last[idx]) clear_pend = 1'b1;
                  rd_ptr++;
               end
            end
         end
      end
   end

   // Consumer: ready high, random, or a 3-cycle stall on row 5.
   always @(posedge clk) begin
      #1;
      if (!hold5_en) hold_n = 0;
      if (hold5_en && out_valid && out_row == 4'd5 && hold_n < 3) begin
         out_ready = 1'b0;
         hold_n++;
      end else if (rdy_rand) begin
         out_ready = ($urandom_range(3) != 0);
      end else begin
         out_ready = 1'b1;
      end
   end

   task automatic issue(input bit cv, input int sel,
                        input logic [ROWS-1:0] tbl, input bit iv,
                        input logic [N_IN-1:0] d, input bit sw);
      bit pend;
      int n;
      pend = iv;
      n = 0;
      cfg_valid   = cv;
      cfg_sel     = SEL_W'(sel);
      cfg_table   = tbl;
      in_valid    = iv;
      in_data     = d;
      sweep_start = sw;
      do begin
         @(negedge clk);
         #1;
         if (in_valid && in_ready) begin
            push(in_data, 1'b0);
            pend = 1'b0;
         end
         if (cfg_valid && !busy_now() && sel < N_OUT) model[sel] = tbl;
         if (sweep_start && !busy_now()) begin
            for (int r = 0; r < ROWS; r++) push(N_IN'(r), r == ROWS - 1);
            sw_started++;
         end
         @(posedge clk);
         #1;
         cfg_valid   = 1'b0;
         sweep_start = 1'b0;
         n++;
      end while (pend && n < 300);
      in_valid = 1'b0;
      if (pend) tmo_flag = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rd_ptr != wr_ptr || busy_now()) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 400) tmo_flag = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int op;
      int sel;
      logic [ROWS-1:0] tbl;
      logic [N_IN-1:0] d;
      for (int k = 0; k < N_OUT; k++) model[k] = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(1, 0, 16'h8000, 0, 4'h0, 0);
      issue(0, 0, '0, 1, 4'hF, 0);
      issue(0, 0, '0, 1, 4'hE, 0);

      issue(1, 1, 16'h6996, 0, 4'h0, 0);
      issue(0, 0, '0, 0, 4'h0, 1);
      drain();

      hold5_en = 1'b1;
      issue(0, 0, '0, 0, 4'h0, 1);
      drain();
      hold5_en = 1'b0;

      issue(1, 0, 16'h0000, 0, 4'h0, 0);
      issue(1, 0, 16'hFFFF, 1, 4'h3, 0);
      issue(0, 0, '0, 1, 4'h3, 0);

      issue(1, 12, 16'hFFFF, 0, 4'h0, 0);
      for (int r = 0; r < ROWS; r += 5) issue(0, 0, '0, 1, N_IN'(r), 0);

      issue(0, 0, '0, 0, 4'h0, 1);
      cfg_valid   = 1'b1;
      cfg_sel     = '0;
      cfg_table   = 16'h1234;
      in_valid    = 1'b1;
      in_data     = 4'h9;
      sweep_start = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      cfg_valid   = 1'b0;
      in_valid    = 1'b0;
      sweep_start = 1'b0;
      drain();
      issue(0, 0, '0, 1, 4'h9, 0);
      issue(0, 0, '0, 1, 4'h3, 0);

      for (int it = 0; it < 250; it++) begin
         if (it % 50 == 0) rdy_rand = ($urandom_range(1) == 1);
         op  = $urandom_range(9);
         sel = $urandom_range(15);
         tbl = ROWS'($urandom);
         d   = N_IN'($urandom);
         case (op)
            0, 1, 2: issue(0, sel, tbl, 1, d, 0);
            3, 4:    issue(1, sel, tbl, 0, d, 0);
            5, 6:    issue(1, sel, tbl, 1, d, 0);
            7:       issue(0, sel, tbl, $urandom_range(1) == 1, d, 1);
            default: begin
               @(posedge clk);
               #1;
            end
         endcase
      end
      rdy_rand = 1'b0;
      drain();

      issue(0, 0, '0, 0, 4'h0, 1);
      n = 0;
      while (!(out_valid && out_row == 4'd7) && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 100) tmo_flag = 1'b1;
      rst_n = 1'b0;
      for (int k = 0; k < N_OUT; k++) model[k] = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int r = 0; r < ROWS; r++) issue(0, 0, '0, 1, N_IN'(r), 0);
      drain();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
